uart_tx_arbiter: RTL and testbench

//  Shares the single UART transmitter between two byte producers: A (ALU-result path) and B (status/echo path).

---
 rtl/uart_tx_arbiter.sv | 157 +++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter.sv
// Round-robin sharing of one UART transmitter between two byte producers,
// each buffered by a small FIFO, with a watchdog on the tx handshake.

module uart_tx_arbiter_fifo #(
  parameter int Bits  = 8,
  parameter int DEPTH = 4
) (
  input  logic            i_clk,
  input  logic            i_reset,
  input  logic            i_push,
  input  logic [Bits-1:0] i_data,
  input  logic            i_pop,
  output logic [Bits-1:0] o_head,
  output logic            o_ready,
  output logic            o_empty
);
  localparam int AW = $clog2(DEPTH);

  logic [Bits-1:0] mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [AW:0]     count;
  logic            do_push;
  logic            do_pop;

  // Readiness comes from the registered count only, so a full FIFO refuses
  // a push even while it is being popped.
  assign o_ready = (count != (AW+1)'(DEPTH));
  assign o_empty = (count == '0);
  assign do_push = i_push & o_ready;
  assign do_pop  = i_pop & ~o_empty;
  assign o_head  = mem[rd_ptr];

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (do_push) mem[wr_ptr] <= i_data;
  end
endmodule

// state | meaning
// IDLE  | waiting for a queued byte and an idle transmitter
// START | byte latched on o_tx_data, tx_start pulse this cycle
// WAIT  | holding the grant until tx_done or watchdog expiry
module uart_tx_arbiter #(
  parameter int Bits    = 8,
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 100000,
  parameter int TO_W    = 17
) (
  input  logic            i_clk,
  input  logic            i_reset,
  input  logic            i_a_valid,
  input  logic [Bits-1:0] i_a_data,
  output logic            o_a_ready,
  input  logic            i_b_valid,
  input  logic [Bits-1:0] i_b_data,
  output logic            o_b_ready,
  output logic            o_tx_start,
  output logic [Bits-1:0] o_tx_data,
  input  logic            i_tx_active,
  input  logic            i_tx_done,
  output logic            o_timeout,
  output logic            o_busy
);
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] START = 2'd1;
  localparam logic [1:0] WAIT  = 2'd2;

  logic [1:0]      state;
  logic            last_grant_b;
  logic [TO_W-1:0] wdog;
  logic [Bits-1:0] a_head;
  logic [Bits-1:0] b_head;
  logic            a_empty;
  logic            b_empty;
  logic            launch;
  logic            grant_a;
  logic            pop_a;
  logic            pop_b;
  logic            expire;

  uart_tx_arbiter_fifo #(.Bits(Bits), .DEPTH(DEPTH)) u_fifo_a (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_push  (i_a_valid),
    .i_data  (i_a_data),
    .i_pop   (pop_a),
    .o_head  (a_head),
    .o_ready (o_a_ready),
    .o_empty (a_empty)
  );

  uart_tx_arbiter_fifo #(.Bits(Bits), .DEPTH(DEPTH)) u_fifo_b (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_push  (i_b_valid),
    .i_data  (i_b_data),
    .i_pop   (pop_b),
    .o_head  (b_head),
    .o_ready (o_b_ready),
    .o_empty (b_empty)
  );

  assign launch  = (state == IDLE) && !(a_empty && b_empty) && !i_tx_active;
  assign grant_a = !a_empty && (b_empty || last_grant_b);
  assign pop_a   = launch & grant_a;
  assign pop_b   = launch & ~grant_a;

  // A done in the expiry cycle wins, so the watchdog pulse is suppressed.
  assign expire     = (state == WAIT) && !i_tx_done && (wdog == TO_W'(TIMEOUT - 1));
  assign o_timeout  = expire;
  assign o_tx_start = (state == START);
  assign o_busy     = (state != IDLE);

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state        <= IDLE;
      last_grant_b <= 1'b1;
      wdog         <= '0;
      o_tx_data    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (launch) begin
            o_tx_data    <= grant_a ? a_head : b_head;
            last_grant_b <= ~grant_a;
            state        <= START;
          end
        end
        START: begin
          wdog  <= '0;
          state <= WAIT;
        end
        WAIT: begin
          if (i_tx_done || expire) state <= IDLE;
          else                     wdog  <= wdog + 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: directed scenarios plus random traffic, checked
// every cycle against a queue-based model of the arbiter.

module tb_uart_tx_arbiter;
  localparam int DEPTH   = 4;
  localparam int TIMEOUT = 16;

  logic       i_clk = 1'b0;
  logic       i_reset;
  logic       i_a_valid, i_b_valid;
  logic [7:0] i_a_data, i_b_data;
  logic       o_a_ready, o_b_ready;
  logic       o_tx_start, o_timeout, o_busy;
  logic [7:0] o_tx_data;
  logic       i_tx_active, i_tx_done;

  uart_tx_arbiter #(.Bits(8), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT), .TO_W(5)) dut (
    .i_clk       (i_clk),
    .i_reset     (i_reset),
    .i_a_valid   (i_a_valid),
    .i_a_data    (i_a_data),
    .o_a_ready   (o_a_ready),
    .i_b_valid   (i_b_valid),
    .i_b_data    (i_b_data),
    .o_b_ready   (o_b_ready),
    .o_tx_start  (o_tx_start),
    .o_tx_data   (o_tx_data),
    .i_tx_active (i_tx_active),
    .i_tx_done   (i_tx_done),
    .o_timeout   (o_timeout),
    .o_busy      (o_busy)
  );

  always #5 i_clk = ~i_clk;

  int n_pass = 0;
  int n_total = 0;
  int cyc = 0;

  // Model: queued bytes per requester, transmitter ownership and its age
  // in cycles since the pop (age 0 is the start cycle).
  logic [7:0] qa[$];
  logic [7:0] qb[$];
  bit         m_busy;
  int         m_age;
  bit         m_last_b;
  logic [7:0] m_data;

  logic [7:0] started[$];
  int         start_cycs[$];
  int         to_cycs[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h cycle=%0d", tag, obs, exp, cyc);
  endtask

  task automatic model_reset();
    qa.delete();
    qb.delete();
    m_busy   = 0;
    m_age    = 0;
    m_last_b = 1;
    m_data   = 8'h00;
  endtask

  task automatic clear_logs();
    started.delete();
    start_cycs.delete();
    to_cycs.delete();
  endtask

  task automatic step(input logic va, input logic [7:0] da, input logic vb,
                      input logic [7:0] db, input logic act, input logic done);
    bit acc_a, acc_b, ga;
    @(negedge i_clk);
    i_a_valid = va; i_a_data = da;
    i_b_valid = vb; i_b_data = db;
    i_tx_active = act; i_tx_done = done;
    #1;
    chk("a_ready",  32'(o_a_ready),  32'(qa.size() < DEPTH));
    chk("b_ready",  32'(o_b_ready),  32'(qb.size() < DEPTH));
    chk("tx_start", 32'(o_tx_start), 32'(m_busy && m_age == 0));
    chk("timeout",  32'(o_timeout),  32'(m_busy && m_age == TIMEOUT && !done));
    chk("busy",     32'(o_busy),     32'(m_busy));
    chk("tx_data",  32'(o_tx_data),  32'(m_data));
    if (o_tx_start === 1'b1) begin
      started.push_back(o_tx_data);
      start_cycs.push_back(cyc);
    end
    if (o_timeout === 1'b1) to_cycs.push_back(cyc);
    acc_a = va && (qa.size() < DEPTH);
    acc_b = vb && (qb.size() < DEPTH);
    if (!m_busy) begin
      if ((qa.size() > 0 || qb.size() > 0) && !act) begin
        ga       = (qa.size() > 0) && (qb.size() == 0 || m_last_b);
        m_data   = ga ? qa.pop_front() : qb.pop_front();
        m_last_b = !ga;
        m_busy   = 1;
        m_age    = 0;
      end
    end else if (m_age == 0) begin
      m_age = 1;
    end else if (done || m_age == TIMEOUT) begin
      m_busy = 0;
    end else begin
      m_age++;
    end
    if (acc_a) qa.push_back(da);
    if (acc_b) qb.push_back(db);
    cyc++;
  endtask

  task automatic idle(input int n, input int done_at);
    for (int i = 0; i < n; i++)
      step(0, 8'h00, 0, 8'h00, 0, (done_at >= 0) && m_busy && (m_age == done_at));
  endtask

  task automatic do_reset();
    @(negedge i_clk);
    i_reset = 1'b1;
    i_a_valid = 0; i_b_valid = 0; i_a_data = 0; i_b_data = 0;
    i_tx_active = 0; i_tx_done = 0;
    #1;
    chk("rst_start", 32'(o_tx_start), 32'd0);
    chk("rst_data",  32'(o_tx_data),  32'd0);
    chk("rst_to",    32'(o_timeout),  32'd0);
    chk("rst_busy",  32'(o_busy),     32'd0);
    chk("rst_a_rdy", 32'(o_a_ready),  32'd1);
    chk("rst_b_rdy", 32'(o_b_ready),  32'd1);
    model_reset();
    @(negedge i_clk);
    i_reset = 1'b0;
    cyc += 2;
  endtask

  initial begin
    int acc_cyc, fall_cyc, tries;
    bit was_full;
    i_reset = 1'b1;
    i_a_valid = 0; i_b_valid = 0; i_a_data = 0; i_b_data = 0;
    i_tx_active = 0; i_tx_done = 0;
    model_reset();

    // single A byte, done 10 cycles after start
    do_reset(); clear_logs();
    acc_cyc = cyc;
    step(1, 8'h3C, 0, 8'h00, 0, 0);
    idle(20, 10);
    chk("t1_starts", 32'(started.size()), 32'd1);
    chk("t1_byte", 32'(started[0]), 32'h3C);
    chk("t1_latency", 32'(start_cycs[0] - acc_cyc), 32'd2);
    chk("t1_idle", 32'(o_busy), 32'd0);

    // preloaded A and B alternate
    do_reset(); clear_logs();
    step(1, 8'h01, 1, 8'h81, 1, 0);
    step(1, 8'h02, 1, 8'h82, 1, 0);
    idle(60, 5);
    chk("t2_starts", 32'(started.size()), 32'd4);
    chk("t2_b0", 32'(started[0]), 32'h01);
    chk("t2_b1", 32'(started[1]), 32'h81);
    chk("t2_b2", 32'(started[2]), 32'h02);
    chk("t2_b3", 32'(started[3]), 32'h82);

    // watchdog with done held low
    do_reset(); clear_logs();
    step(1, 8'h11, 0, 8'h00, 0, 0);
    step(1, 8'h22, 0, 8'h00, 0, 0);
    idle(60, -1);
    chk("t3_to_cnt", 32'(to_cycs.size()), 32'd2);
    chk("t3_to_dist", 32'(to_cycs[0] - start_cycs[0]), 32'd16);
    chk("t3_next", 32'(started[1]), 32'h22);
    chk("t3_after", 32'(start_cycs[1] > to_cycs[0]), 32'd1);

    // overfill A while the transmitter is busy
    do_reset(); clear_logs();
    for (int i = 0; i < 4; i++) step(1, 8'hA0 + 8'(i), 0, 8'h00, 1, 0);
    @(posedge i_clk); #1;
    chk("t4_full", 32'(o_a_ready), 32'd0);
    for (int i = 0; i < 3; i++) step(1, 8'hA4, 0, 8'h00, 1, 0);
    tries = 0;
    do begin
      was_full = qa.size() >= DEPTH;
      step(1, 8'hA4, 0, 8'h00, 0, m_busy && m_age == 3);
      tries++;
    end while (was_full && tries < 20);
    chk("t4_accept_bound", 32'(tries < 20), 32'd1);
    idle(60, 3);
    chk("t4_count", 32'(started.size()), 32'd5);
    for (int i = 0; i < 5; i++) chk("t4_order", 32'(started[i]), 32'hA0 + 32'(i));

    // reset while waiting with two bytes queued
    do_reset(); clear_logs();
    for (int i = 0; i < 3; i++) step(1, 8'h51 + 8'(i), 0, 8'h00, 0, 0);
    idle(3, -1);
    chk("t5_waiting", 32'(o_busy), 32'd1);
    do_reset(); clear_logs();
    idle(20, -1);
    chk("t5_silent", 32'(started.size()), 32'd0);
    step(1, 8'h55, 0, 8'h00, 0, 0);
    idle(20, 3);
    chk("t5_new", 32'(started[0]), 32'h55);

    // transmitter busy elsewhere holds the arbiter in IDLE
    do_reset(); clear_logs();
    step(1, 8'h66, 0, 8'h00, 1, 0);
    for (int i = 0; i < 5; i++) step(0, 8'h00, 0, 8'h00, 1, 0);
    chk("t6_held", 32'(started.size()), 32'd0);
    fall_cyc = cyc;
    idle(20, 4);
    chk("t6_lat", 32'(start_cycs[0] - fall_cyc), 32'd1);

    // random traffic, including stray done pulses and occasional timeouts
    do_reset(); clear_logs();
    for (int i = 0; i < 600; i++)
      step(1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 1)), 8'($urandom),
           $urandom_range(0, 9) == 0, $urandom_range(0, 7) == 0);
    idle(200, 2);
    chk("rnd_drain", 32'(o_busy), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
